alu_exec_stage: RTL and testbench

- Registered RV32I execute stage: accepts decoded operands and an ALU opcode from ID/EX, computes the result in one cycle, and presents it to the MEM stage.
- Instantiates the team's combinational adder, logic and shift units, including the arithmetic right shifter.
- Uses a valid/ready handshake on both sides.
- Contains a 2-entry skid buffer, so downstream back-pressure never drops an accepted operation.

---
 rtl/alu_exec_stage.sv | 137 +++++++++++++
 tb/tb_alu_exec_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered RV32I execute stage with 2-entry skid buffer
// Combinational adder, logic and shift units feed a valid/ready OUT+SKID output pair.

module alu_add_unit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);
  assign sum = a + (sub ? ~b : b) + {{(N-1){1'b0}}, sub};
endmodule

module alu_logic_unit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   sel,
  output logic [N-1:0] result
);
  always_comb begin
    case (sel)
      2'd0:    result = a ^ b;
      2'd1:    result = a | b;
      default: result = a & b;
    endcase
  end
endmodule

module alu_shift_unit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [4:0]   shamt,
  input  logic         right,
  input  logic         arith,
  output logic [N-1:0] result
);
  always_comb begin
    if (!right)
      result = a << shamt;
    else if (arith)
      result = $unsigned($signed(a) >>> shamt);
    else
      result = a >> shamt;
  end
endmodule

module alu_exec_stage #(
  parameter int N    = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            out_zero
);
  logic [N-1:0]    sum, logic_res, shift_res, alu_res;
  logic            out_v, skid_v;
  logic [N-1:0]    out_res, skid_res;
  logic [TAGW-1:0] out_tg, skid_tg;
  logic            accept, drain;
  logic [1:0]      logic_sel;

  assign logic_sel = (in_op == 4'd5) ? 2'd0 : (in_op == 4'd8) ? 2'd1 : 2'd2;

  alu_add_unit #(.N(N)) u_add (
    .a(in_a), .b(in_b), .sub(in_op == 4'd1), .sum(sum)
  );

  alu_logic_unit #(.N(N)) u_logic (
    .a(in_a), .b(in_b), .sel(logic_sel), .result(logic_res)
  );

  alu_shift_unit #(.N(N)) u_shift (
    .a(in_a), .shamt(in_b[4:0]), .right(in_op != 4'd2), .arith(in_op == 4'd7),
    .result(shift_res)
  );

  always_comb begin
    alu_res = '0;
    case (in_op)
      4'd0, 4'd1:       alu_res = sum;
      4'd2, 4'd6, 4'd7: alu_res = shift_res;
      4'd3:             alu_res = {{(N-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'd4:             alu_res = {{(N-1){1'b0}}, in_a < in_b};
      4'd5, 4'd8, 4'd9: alu_res = logic_res;
      default:          alu_res = '0;
    endcase
  end

  // in_ready comes straight from the SKID valid flop, so out_ready never reaches it
  assign in_ready   = ~skid_v;
  assign accept     = in_valid & ~skid_v;
  assign drain      = out_v & out_ready;
  assign out_valid  = out_v;
  assign out_result = out_res;
  assign out_tag    = out_tg;
  assign out_zero   = (out_res == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
      out_res  <= '0;
      out_tg   <= '0;
      skid_res <= '0;
      skid_tg  <= '0;
    end else if (drain && skid_v) begin
      out_res <= skid_res;
      out_tg  <= skid_tg;
      skid_v  <= 1'b0;
    end else if (accept && (!out_v || drain)) begin
      out_v   <= 1'b1;
      out_res <= alu_res;
      out_tg  <= in_tag;
    end else if (accept) begin
      skid_v   <= 1'b1;
      skid_res <= alu_res;
      skid_tg  <= in_tag;
    end else if (drain) begin
      out_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed and random self-checking bench for alu_exec_stage
// Expected results come from an arithmetic reference model of the opcode table.

module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  int          checks = 0;
  int          failures = 0;

  alu_exec_stage #(.N(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] pw;
    int signed   sa, sb;
    pw = 32'd1 << b[4:0];
    sa = a;
    sb = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * pw;
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a / pw;
      // floor division of a negative value: ~(~a / 2^k)
      4'd7: return a[31] ? ~((~a) / pw) : a / pw;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_tag;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    drive(1'b1, 4'd7, 32'h8000_0000, 32'h0000_0004, 5'd1);
    tick();
    chk("sra_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_result", out_result, 32'hF800_0000);
    chk("sra_zero", {31'd0, out_zero}, 32'd0);
    drive(1'b1, 4'd6, 32'h8000_0000, 32'hFFFF_FFE4, 5'd2);
    tick();
    chk("srl_result", out_result, 32'h0800_0000);
    drive(1'b1, 4'd2, 32'd1, 32'd31, 5'd3);
    tick();
    chk("sll_result", out_result, 32'h8000_0000);
    drive(1'b1, 4'd1, 32'd5, 32'd5, 5'd4);
    tick();
    chk("sub_result", out_result, 32'd0);
    chk("sub_zero", {31'd0, out_zero}, 32'd1);
    chk("sub_tag", {27'd0, out_tag}, 32'd4);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // back-pressure: three ops, the third must wait for SKID to clear
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd10, 32'd1, 5'd1);
    tick();
    chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp1_tag", {27'd0, out_tag}, 32'd1);
    drive(1'b1, 4'd0, 32'd20, 32'd2, 5'd2);
    tick();
    chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 4'd0, 32'd30, 32'd3, 5'd3);
    tick();
    chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3_hold_tag", {27'd0, out_tag}, 32'd1);
    chk("bp3_hold_result", out_result, 32'd11);
    out_ready = 1'b1;
    tick();
    chk("drain_tag2", {27'd0, out_tag}, 32'd2);
    chk("drain_res2", out_result, 32'd22);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("drain_tag3", {27'd0, out_tag}, 32'd3);
    chk("drain_res3", out_result, 32'd33);
    chk("drain_valid3", {31'd0, out_valid}, 32'd1);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // streaming random ops at full throughput
    for (int i = 0; i < 100; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 7) == 0) ? r_a : $urandom;
      r_tag = 5'($urandom);
      drive(1'b1, r_op, r_a, r_b, r_tag);
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_result", out_result, ref_alu(r_op, r_a, r_b));
      chk("stream_tag", {27'd0, out_tag}, {27'd0, r_tag});
      chk("stream_zero", {31'd0, out_zero}, {31'd0, ref_alu(r_op, r_a, r_b) == 32'd0});
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    tick();

    // flush with both entries full and a new op presented
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd4);
    tick();
    drive(1'b1, 4'd0, 32'd2, 32'd2, 5'd5);
    tick();
    chk("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 4'd0, 32'd3, 32'd3, 5'd6);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

    // reset in the middle of a held result
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd3, 32'd4, 5'd7);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_result", out_result, 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_tag", {27'd0, out_tag}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 4'd12, 32'd5, 32'd6, 5'd9);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("op12_valid", {31'd0, out_valid}, 32'd1);
    chk("op12_result", out_result, 32'd0);
    chk("op12_tag", {27'd0, out_tag}, 32'd9);
    chk("op12_zero", {31'd0, out_zero}, 32'd1);
    tick();
    chk("op12_hold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("op12_drained", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
